// File: rtl/scb_pkg.sv
// Shared types and constants for the SCB SPI command scheduler.
// Sized for the slow-control-board SPI engine command port.
package scb_pkg;

   localparam int SCB_CMD_W   = 136;
   localparam int SCB_RD_W    = 128;
   localparam int SCB_LEN_MAX = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_REL,
      S_DONE
   } state_t;

endpackage

// File: rtl/scb_usec_timer.sv
// Microsecond tick counter with clear, enable and terminal-count pulse.
// tc fires on the tick that would take the count to TERM, then it wraps.
module scb_usec_timer #(
   parameter int TERM = 1000,
   parameter int W    = $clog2(TERM + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic tick,
   output logic tc
);

   logic [W-1:0] count;

   assign tc = en && tick && (count == W'(TERM - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && tick) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/scb_spi_sched.sv
// Arbitrates host writes and periodic monitor readouts onto the single
// SCB SPI engine command port, with a per-transaction watchdog.
module scb_spi_sched
   import scb_pkg::*;
#(
   parameter int MON_PERIOD_US = 1000,
   parameter int TIMEOUT_US    = 5000,
   parameter int MAX_LEN       = SCB_LEN_MAX
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 usec_tick,
   input  logic                 hst_req,
   input  logic [SCB_CMD_W-1:0] hst_cmd,
   input  logic [7:0]           hst_len,
   output logic                 hst_done,
   output logic                 hst_err,
   output logic [SCB_RD_W-1:0]  hst_rdata,
   input  logic                 mon_en,
   input  logic [SCB_CMD_W-1:0] mon_cmd,
   input  logic [7:0]           mon_len,
   output logic [SCB_RD_W-1:0]  mon_rdata,
   output logic                 mon_valid,
   output logic                 timeout_err,
   input  logic                 err_clr,
   output logic                 busy,
   input  logic                 scb_en,
   input  logic                 scb_command_dac_finish,
   output logic                 command_dacset,
   output logic [SCB_CMD_W-1:0] SCB_SPICMD,
   output logic [7:0]           SCB_SPILENGTH,
   input  logic [SCB_RD_W-1:0]  SCB_SPIREAD
);

   state_t state;
   state_t state_nx;

   logic mon_pend;
   logic mon_tc;
   logic wd_tc;
   logic last_mon;
   logic own_mon;
   logic hst_ok;
   logic hst_bad;
   logic pick_mon;
   logic arb;
   logic grant_h;
   logic grant_m;
   logic reject;
   logic enter_done;

   // hst_req is a level held until it sees hst_done; ignore that cycle
   assign hst_ok   = hst_req && !hst_done;
   assign hst_bad  = hst_len > 8'(MAX_LEN);
   assign pick_mon = mon_pend && (!hst_ok || !last_mon);
   assign arb      = (state == S_IDLE) && scb_en;
   assign grant_m  = arb && pick_mon;
   assign grant_h  = arb && hst_ok && !pick_mon && !hst_bad;
   assign reject   = arb && hst_ok && !pick_mon && hst_bad;

   scb_usec_timer #(.TERM(MON_PERIOD_US)) u_mon_tmr (
      .clk  (clk),
      .rst  (rst),
      .clr  (!mon_en),
      .en   (mon_en),
      .tick (usec_tick),
      .tc   (mon_tc)
   );

   scb_usec_timer #(.TERM(TIMEOUT_US)) u_wd_tmr (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == S_LOAD),
      .en   ((state == S_REQ) || (state == S_REL)),
      .tick (usec_tick),
      .tc   (wd_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (grant_h || grant_m) state_nx = S_LOAD;
         end
         S_LOAD: state_nx = S_REQ;
         S_REQ: begin
            if (wd_tc)                       state_nx = S_DONE;
            else if (scb_command_dac_finish) state_nx = S_REL;
         end
         S_REL: begin
            if (wd_tc)                                 state_nx = S_DONE;
            else if (!scb_command_dac_finish && scb_en) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign enter_done = (state_nx == S_DONE) && (state != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         hst_done       <= 1'b0;
         hst_err        <= 1'b0;
         hst_rdata      <= '0;
         mon_rdata      <= '0;
         mon_valid      <= 1'b0;
         mon_pend       <= 1'b0;
         timeout_err    <= 1'b0;
         busy           <= 1'b0;
         command_dacset <= 1'b0;
         SCB_SPICMD     <= '0;
         SCB_SPILENGTH  <= '0;
         own_mon        <= 1'b0;
         last_mon       <= 1'b1;
      end else begin
         hst_done  <= 1'b0;
         hst_err   <= 1'b0;
         mon_valid <= 1'b0;

         if (reject) begin
            hst_done <= 1'b1;
            hst_err  <= 1'b1;
         end

         if (grant_h || grant_m) begin
            SCB_SPICMD    <= grant_m ? mon_cmd : hst_cmd;
            SCB_SPILENGTH <= grant_m ? mon_len : hst_len;
            own_mon       <= grant_m;
            last_mon      <= grant_m;
            busy          <= 1'b1;
         end

         if (state == S_LOAD) command_dacset <= 1'b1;

         // a watchdog expiry on the finish edge discards the read-back
         if (state == S_REQ && scb_command_dac_finish && !wd_tc) begin
            command_dacset <= 1'b0;
            if (own_mon) mon_rdata <= SCB_SPIREAD;
            else         hst_rdata <= SCB_SPIREAD;
         end

         if (wd_tc) command_dacset <= 1'b0;

         if (wd_tc)        timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;

         if (enter_done) begin
            hst_done  <= !own_mon;
            hst_err   <= !own_mon && wd_tc;
            mon_valid <= own_mon && !wd_tc;
         end

         if (state == S_DONE) busy <= 1'b0;

         if (!mon_en)                          mon_pend <= 1'b0;
         else if (state == S_DONE && own_mon) mon_pend <= 1'b0;
         else if (mon_tc)                      mon_pend <= 1'b1;
      end
   end

endmodule
